// File: rtl/tft_spi_decoder_pkg.sv
// Shared opcodes and decoder state encoding for the TFT SPI receive path.
package tft_pkg;

   localparam logic [7:0] CMD_CASET = 8'h2A;
   localparam logic [7:0] CMD_PASET = 8'h2B;
   localparam logic [7:0] CMD_RAMWR = 8'h2C;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_CASET    = 3'd1,
      ST_PASET    = 3'd2,
      ST_RAMWR_HI = 3'd3,
      ST_RAMWR_LO = 3'd4
   } dec_state_t;

endpackage

// File: rtl/tft_spi_decoder_rx.sv
// Pin synchronizers, SCK rise detect and 8-bit MSB-first byte assembly.
module spi_byte_rx (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       tft_sck,
   input  logic       tft_sdi,
   input  logic       tft_dc,
   input  logic       tft_cs,
   input  logic       tft_reset,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       byte_dc,
   output logic       cs_high,
   output logic       panel_rst
);

   logic [1:0] sck_s_q, sdi_s_q, dc_s_q, cs_s_q, prst_s_q;
   logic       sck_d_q, rise_q, sdi_q, dc_q, cs_q;
   logic [7:0] shift_q, data_q;
   logic [2:0] cnt_q;
   logic       valid_q, dcb_q;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         sck_s_q  <= 2'b00;
         sdi_s_q  <= 2'b00;
         dc_s_q   <= 2'b00;
         cs_s_q   <= 2'b11;
         prst_s_q <= 2'b11;
         sck_d_q  <= 1'b0;
         rise_q   <= 1'b0;
         sdi_q    <= 1'b0;
         dc_q     <= 1'b0;
         cs_q     <= 1'b1;
         shift_q  <= 8'h00;
         cnt_q    <= 3'd0;
         valid_q  <= 1'b0;
         data_q   <= 8'h00;
         dcb_q    <= 1'b0;
      end else begin
         sck_s_q  <= {sck_s_q[0], tft_sck};
         sdi_s_q  <= {sdi_s_q[0], tft_sdi};
         dc_s_q   <= {dc_s_q[0], tft_dc};
         cs_s_q   <= {cs_s_q[0], tft_cs};
         prst_s_q <= {prst_s_q[0], tft_reset};
         // SDI/DC/CS are delayed alongside the registered rise so all line up
         sck_d_q  <= sck_s_q[1];
         rise_q   <= sck_s_q[1] & ~sck_d_q;
         sdi_q    <= sdi_s_q[1];
         dc_q     <= dc_s_q[1];
         cs_q     <= cs_s_q[1];
         valid_q  <= 1'b0;
         if (!prst_s_q[1]) begin
            shift_q <= 8'h00;
            cnt_q   <= 3'd0;
            data_q  <= 8'h00;
            dcb_q   <= 1'b0;
         end else if (cs_q) begin
            shift_q <= 8'h00;
            cnt_q   <= 3'd0;
         end else if (rise_q) begin
            shift_q <= {shift_q[6:0], sdi_q};
            cnt_q   <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               valid_q <= 1'b1;
               data_q  <= {shift_q[6:0], sdi_q};
               dcb_q   <= dc_q;
            end
         end
      end
   end

   assign byte_valid = valid_q;
   assign byte_data  = data_q;
   assign byte_dc    = dcb_q;
   assign cs_high    = cs_q;
   assign panel_rst  = ~prst_s_q[1];

endmodule

// File: rtl/tft_spi_decoder.sv
// TFT SPI monitor: decodes commands, tracks the CASET/PASET window and emits RGB565 pixel events.
// state    | meaning
// IDLE     | no active command, data bytes ignored
// CASET    | collecting column window bytes 0..3
// PASET    | collecting row window bytes 0..3
// RAMWR_HI | waiting for pixel high byte
// RAMWR_LO | waiting for pixel low byte
module tft_spi_decoder
   import tft_pkg::*;
#(
   parameter int COL_W       = 8,
   parameter int ROW_W       = 9,
   parameter int COL_END_RST = 239,
   parameter int ROW_END_RST = 319
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             tft_sck,
   input  logic             tft_sdi,
   input  logic             tft_dc,
   input  logic             tft_cs,
   input  logic             tft_reset,
   output logic             cmd_valid,
   output logic [7:0]       cmd_out,
   output logic             pixel_valid,
   output logic [COL_W-1:0] col_out,
   output logic [ROW_W-1:0] row_out,
   output logic [15:0]      pixel_out
);

   logic       byte_valid, byte_dc, cs_high, panel_rst;
   logic [7:0] byte_data;

   spi_byte_rx u_rx (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .tft_sck    (tft_sck),
      .tft_sdi    (tft_sdi),
      .tft_dc     (tft_dc),
      .tft_cs     (tft_cs),
      .tft_reset  (tft_reset),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_dc    (byte_dc),
      .cs_high    (cs_high),
      .panel_rst  (panel_rst)
   );

   dec_state_t       state_q, state_d;
   logic [1:0]       idx_q;
   logic [15:0]      sh_start_q;
   logic [7:0]       sh_end_hi_q;
   logic [15:0]      col_start_q, col_end_q, row_start_q, row_end_q;
   logic [15:0]      col_q, row_q, col_nxt, row_nxt;
   logic [7:0]       hi_q;
   logic             cmd_valid_q, pix_valid_q;
   logic [7:0]       cmd_q;
   logic [COL_W-1:0] col_out_q;
   logic [ROW_W-1:0] row_out_q;
   logic [15:0]      pix_q;
   logic             is_cmd, is_data;

   assign is_cmd  = byte_valid & ~byte_dc;
   assign is_data = byte_valid & byte_dc;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in)        state_q <= ST_IDLE;
      else if (panel_rst) state_q <= ST_IDLE;
      else                state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (is_cmd) begin
         case (byte_data)
            CMD_CASET: state_d = ST_CASET;
            CMD_PASET: state_d = ST_PASET;
            CMD_RAMWR: state_d = ST_RAMWR_HI;
            default:   state_d = ST_IDLE;
         endcase
      end else if (is_data) begin
         case (state_q)
            ST_CASET, ST_PASET: if (idx_q == 2'd3) state_d = ST_IDLE;
            ST_RAMWR_HI:        state_d = ST_RAMWR_LO;
            ST_RAMWR_LO:        state_d = ST_RAMWR_HI;
            default:            state_d = state_q;
         endcase
      end else if (cs_high && state_q == ST_RAMWR_LO) begin
         state_d = ST_RAMWR_HI;
      end
   end

   // Equality-only wrap: a cursor beyond end keeps counting modulo 2^16
   always_comb begin
      col_nxt = col_q + 16'd1;
      row_nxt = row_q;
      if (col_q == col_end_q) begin
         col_nxt = col_start_q;
         row_nxt = (row_q == row_end_q) ? row_start_q : row_q + 16'd1;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         idx_q <= 2'd0; sh_start_q <= 16'h0; sh_end_hi_q <= 8'h0;
         col_start_q <= 16'h0; col_end_q <= 16'(COL_END_RST);
         row_start_q <= 16'h0; row_end_q <= 16'(ROW_END_RST);
         col_q <= 16'h0; row_q <= 16'h0; hi_q <= 8'h0;
         cmd_valid_q <= 1'b0; cmd_q <= 8'h0; pix_valid_q <= 1'b0;
         col_out_q <= '0; row_out_q <= '0; pix_q <= 16'h0;
      end else if (panel_rst) begin
         idx_q <= 2'd0; sh_start_q <= 16'h0; sh_end_hi_q <= 8'h0;
         col_start_q <= 16'h0; col_end_q <= 16'(COL_END_RST);
         row_start_q <= 16'h0; row_end_q <= 16'(ROW_END_RST);
         col_q <= 16'h0; row_q <= 16'h0; hi_q <= 8'h0;
         cmd_valid_q <= 1'b0; cmd_q <= 8'h0; pix_valid_q <= 1'b0;
         col_out_q <= '0; row_out_q <= '0; pix_q <= 16'h0;
      end else begin
         cmd_valid_q <= 1'b0;
         pix_valid_q <= 1'b0;
         if (is_cmd) begin
            cmd_valid_q <= 1'b1;
            cmd_q       <= byte_data;
            idx_q       <= 2'd0;
            if (byte_data == CMD_RAMWR) begin
               col_q <= col_start_q;
               row_q <= row_start_q;
            end
         end else if (is_data) begin
            case (state_q)
               ST_CASET, ST_PASET: begin
                  idx_q <= idx_q + 2'd1;
                  case (idx_q)
                     2'd0: sh_start_q[15:8] <= byte_data;
                     2'd1: sh_start_q[7:0]  <= byte_data;
                     2'd2: sh_end_hi_q      <= byte_data;
                     default: begin
                        if (state_q == ST_CASET) begin
                           col_start_q <= sh_start_q;
                           col_end_q   <= {sh_end_hi_q, byte_data};
                        end else begin
                           row_start_q <= sh_start_q;
                           row_end_q   <= {sh_end_hi_q, byte_data};
                        end
                     end
                  endcase
               end
               ST_RAMWR_HI: hi_q <= byte_data;
               ST_RAMWR_LO: begin
                  pix_valid_q <= 1'b1;
                  col_out_q   <= col_q[COL_W-1:0];
                  row_out_q   <= row_q[ROW_W-1:0];
                  pix_q       <= {hi_q, byte_data};
                  col_q       <= col_nxt;
                  row_q       <= row_nxt;
               end
               default: ;
            endcase
         end
      end
   end

   assign cmd_valid   = cmd_valid_q;
   assign cmd_out     = cmd_q;
   assign pixel_valid = pix_valid_q;
   assign col_out     = col_out_q;
   assign row_out     = row_out_q;
   assign pixel_out   = pix_q;

endmodule

// File: tb/tb_tft_spi_decoder.sv
// Directed bench for tft_spi_decoder: byte table plus hand sequences for abort and reset cases.
module tb_tft_spi_decoder;
   import tft_pkg::*;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        sck = 1'b0, sdi = 1'b0, dc = 1'b0, cs = 1'b1, prst = 1'b1;
   logic        cmd_valid, pixel_valid;
   logic [7:0]  cmd_out;
   logic [7:0]  col_out;
   logic [8:0]  row_out;
   logic [15:0] pixel_out;

   tft_spi_decoder dut (
      .clk_in      (clk),
      .rst_in      (rst_n),
      .tft_sck     (sck),
      .tft_sdi     (sdi),
      .tft_dc      (dc),
      .tft_cs      (cs),
      .tft_reset   (prst),
      .cmd_valid   (cmd_valid),
      .cmd_out     (cmd_out),
      .pixel_valid (pixel_valid),
      .col_out     (col_out),
      .row_out     (row_out),
      .pixel_out   (pixel_out)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   logic [7:0]  cmdq[$];
   logic [47:0] pixq[$];
   logic        cv_d = 1'b0, pv_d = 1'b0;

   always @(negedge clk) begin
      if (cmd_valid) begin
         cmdq.push_back(cmd_out);
         total++;
         if (cv_d) begin bad++; $display("FAIL cmd_pulse_width: got 2+ cycles want 1"); end
      end
      if (pixel_valid) begin
         pixq.push_back({8'h00, col_out, 7'h00, row_out, pixel_out});
         total++;
         if (pv_d) begin bad++; $display("FAIL pix_pulse_width: got 2+ cycles want 1"); end
      end
      cv_d = cmd_valid;
      pv_d = pixel_valid;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // Eight bits MSB first, 4 clk low / 4 clk high; lat = posedges from 8th rise to first event.
   task automatic send_byte(input logic d, input logic [7:0] b, output int lat);
      lat = 0;
      dc  = d;
      for (int i = 7; i >= 0; i--) begin
         sdi = b[i];
         clks(4);
         sck = 1'b1;
         if (i > 0) begin
            clks(4);
            sck = 1'b0;
         end else begin
            for (int k = 1; k <= 8; k++) begin
               @(posedge clk); #1;
               if (lat == 0 && (cmd_valid || pixel_valid)) lat = k;
               if (k == 4) sck = 1'b0;
            end
         end
      end
   endtask

   task automatic send_bits(input int n);
      dc = 1'b0;
      for (int i = 0; i < n; i++) begin
         sdi = 1'b1;
         clks(4);
         sck = 1'b1;
         clks(4);
         sck = 1'b0;
      end
   endtask

   task automatic expect_none(input string name);
      check(name, 32'(cmdq.size() + pixq.size()), 32'd0);
      cmdq.delete();
      pixq.delete();
   endtask

   task automatic expect_cmd(input string name, input logic [7:0] exp);
      check({name, "_n"}, 32'(cmdq.size()), 32'd1);
      check({name, "_px"}, 32'(pixq.size()), 32'd0);
      if (cmdq.size() > 0) check(name, 32'(cmdq[0]), 32'(exp));
      cmdq.delete();
      pixq.delete();
   endtask

   task automatic expect_pix(input string name, input int col, input int row, input logic [15:0] pix);
      check({name, "_n"}, 32'(pixq.size()), 32'd1);
      check({name, "_cmd"}, 32'(cmdq.size()), 32'd0);
      if (pixq.size() > 0) begin
         check({name, "_col"}, 32'(pixq[0][47:32]), 32'(col));
         check({name, "_row"}, 32'(pixq[0][31:16]), 32'(row));
         check({name, "_pix"}, 32'(pixq[0][15:0]), 32'(pix));
      end
      cmdq.delete();
      pixq.delete();
   endtask

   typedef struct {
      logic        d;
      logic [7:0]  b;
      int          kind;   // 0 none, 1 command, 2 pixel
      logic [15:0] val;
      int          col;
      int          row;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic d, input logic [7:0] b, input int kind,
                      input logic [15:0] val, input int col, input int row);
      vec_t v;
      v.d = d; v.b = b; v.kind = kind; v.val = val; v.col = col; v.row = row;
      vecs.push_back(v);
   endtask

   int lat;

   initial begin
      // window col 100..150, row 200..250
      add(0, 8'h2A, 1, 16'h2A, 0, 0);
      add(1, 8'h00, 0, 0, 0, 0); add(1, 8'h64, 0, 0, 0, 0);
      add(1, 8'h00, 0, 0, 0, 0); add(1, 8'h96, 0, 0, 0, 0);
      add(0, 8'h2B, 1, 16'h2B, 0, 0);
      add(1, 8'h00, 0, 0, 0, 0); add(1, 8'hC8, 0, 0, 0, 0);
      add(1, 8'h00, 0, 0, 0, 0); add(1, 8'hFA, 0, 0, 0, 0);
      add(0, 8'h2C, 1, 16'h2C, 0, 0);
      add(1, 8'hF8, 0, 0, 0, 0); add(1, 8'h00, 2, 16'hF800, 100, 200);
      add(1, 8'h07, 0, 0, 0, 0); add(1, 8'hE0, 2, 16'h07E0, 101, 200);
      // window col 10..11, row 5..6 with wrap of both axes
      add(0, 8'h2A, 1, 16'h2A, 0, 0);
      add(1, 8'h00, 0, 0, 0, 0); add(1, 8'h0A, 0, 0, 0, 0);
      add(1, 8'h00, 0, 0, 0, 0); add(1, 8'h0B, 0, 0, 0, 0);
      add(0, 8'h2B, 1, 16'h2B, 0, 0);
      add(1, 8'h00, 0, 0, 0, 0); add(1, 8'h05, 0, 0, 0, 0);
      add(1, 8'h00, 0, 0, 0, 0); add(1, 8'h06, 0, 0, 0, 0);
      add(0, 8'h2C, 1, 16'h2C, 0, 0);
      add(1, 8'h12, 0, 0, 0, 0); add(1, 8'h34, 2, 16'h1234, 10, 5);
      add(1, 8'h56, 0, 0, 0, 0); add(1, 8'h78, 2, 16'h5678, 11, 5);
      add(1, 8'h9A, 0, 0, 0, 0); add(1, 8'hBC, 2, 16'h9ABC, 10, 6);
      add(1, 8'hDE, 0, 0, 0, 0); add(1, 8'hF0, 2, 16'hDEF0, 11, 6);
      add(1, 8'h11, 0, 0, 0, 0); add(1, 8'h22, 2, 16'h1122, 10, 5);

      clks(4);
      check("rst_cmd_valid", 32'(cmd_valid), 0);
      check("rst_cmd_out", 32'(cmd_out), 0);
      check("rst_pixel_valid", 32'(pixel_valid), 0);
      check("rst_col_row", {15'h0, col_out, row_out}, 0);
      check("rst_pixel_out", 32'(pixel_out), 0);
      rst_n = 1'b1;
      clks(4);
      cs = 1'b0;
      clks(4);

      foreach (vecs[i]) begin
         send_byte(vecs[i].d, vecs[i].b, lat);
         case (vecs[i].kind)
            1: begin
               check("cmd_latency", 32'(lat), 32'd5);
               expect_cmd("tbl_cmd", vecs[i].val[7:0]);
            end
            2: begin
               check("pix_latency", 32'(lat), 32'd5);
               expect_pix("tbl_pix", vecs[i].col, vecs[i].row, vecs[i].val);
               check("pix_hold", 32'(pixel_out), 32'(vecs[i].val));
            end
            default: expect_none("tbl_none");
         endcase
      end

      // CS abort after 5 bits: only the following full byte is decoded
      send_bits(5);
      clks(2);
      cs = 1'b1;
      clks(10);
      cs = 1'b0;
      clks(4);
      expect_none("abort_partial");
      send_byte(0, 8'h2C, lat);
      expect_cmd("abort_cmd", 8'h2C);
      send_byte(1, 8'hAB, lat);
      send_byte(1, 8'hCD, lat);
      expect_pix("abort_pix", 10, 5, 16'hABCD);
      // CS high between pixel bytes drops the pending high byte
      send_byte(1, 8'h55, lat);
      cs = 1'b1;
      clks(10);
      cs = 1'b0;
      clks(4);
      send_byte(1, 8'h66, lat);
      expect_none("drop_hi_none");
      send_byte(1, 8'h77, lat);
      expect_pix("drop_hi_pix", 11, 5, 16'h6677);

      // Reset then partial CASET: window must stay at reset default
      rst_n = 1'b0;
      clks(2);
      rst_n = 1'b1;
      clks(6);
      send_byte(0, 8'h2A, lat);
      expect_cmd("partial_caset_cmd", 8'h2A);
      send_byte(1, 8'h00, lat);
      send_byte(1, 8'h05, lat);
      expect_none("partial_caset_data");
      send_byte(0, 8'h2C, lat);
      expect_cmd("partial_ramwr_cmd", 8'h2C);
      send_byte(1, 8'h12, lat);
      send_byte(1, 8'h34, lat);
      expect_pix("partial_pix0", 0, 0, 16'h1234);
      send_byte(1, 8'h56, lat);
      send_byte(1, 8'h78, lat);
      expect_pix("partial_pix1", 1, 0, 16'h5678);

      // Async reset mid-RAMWR byte clears outputs without a clock edge
      send_byte(1, 8'h99, lat);
      send_bits(3);
      check("pre_rst_cmd_out", 32'(cmd_out), 32'h2C);
      rst_n = 1'b0;
      #2;
      check("async_rst_cmd_out", 32'(cmd_out), 0);
      check("async_rst_pixel_out", 32'(pixel_out), 0);
      check("async_rst_col", 32'(col_out), 0);
      rst_n = 1'b1;
      clks(6);
      send_byte(1, 8'h12, lat);
      send_byte(1, 8'h34, lat);
      send_byte(1, 8'h56, lat);
      send_byte(1, 8'h78, lat);
      expect_none("post_rst_no_pixel");

      // Panel reset pin acts as a synchronous reset
      send_byte(0, 8'h2B, lat);
      expect_cmd("prst_cmd", 8'h2B);
      prst = 1'b0;
      clks(6);
      check("panel_rst_cmd_out", 32'(cmd_out), 0);
      prst = 1'b1;
      clks(6);
      send_byte(0, 8'h2C, lat);
      expect_cmd("prst_ramwr", 8'h2C);
      send_byte(1, 8'hA5, lat);
      send_byte(1, 8'h5A, lat);
      expect_pix("prst_pix", 0, 0, 16'hA55A);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tft_spi_decoder.md
# tft_spi_decoder

Receive-side decoder for the TFT SPI link driven by `display`. It oversamples `tft_sck`/`tft_sdi`/`tft_dc`/`tft_cs`/`tft_reset` on the system clock and assembles bytes. It tracks the controller's column/page address window (CASET/PASET) and emits one pixel-write event per RGB565 pixel streamed after RAMWR. It serves as a synthesizable bus monitor for on-chip checking and as the scoreboard front end in display benches.

## Interface
- `COL_W`, default 8: width of `col_out`.
- `ROW_W`, default 9: width of `row_out`.
- `COL_END_RST`, default 239: column window end after reset.
- `ROW_END_RST`, default 319: row window end after reset.

Ports:
- `clk_in` input 1: system clock.
- `rst_in` input 1: reset, asynchronous, active-low.
- `tft_sck` input 1: SPI clock, asynchronous to `clk_in`.
- `tft_sdi` input 1: SPI data, MSB first.
- `tft_dc` input 1: 0 = command byte, 1 = data byte.
- `tft_cs` input 1: chip select, active-low.
- `tft_reset` input 1: panel reset, active-low.
- `cmd_valid` output 1: one-cycle pulse when a command byte is received.
- `cmd_out` output 8: last command byte.
- `pixel_valid` output 1: one-cycle pulse per decoded pixel.
- `col_out` output COL_W: pixel column, truncated from 16-bit cursor.
- `row_out` output ROW_W: pixel row, truncated from 16-bit cursor.
- `pixel_out` output 16: RGB565 pixel, high byte first on the wire.

## Operation
- Each pin passes through a 2-FF synchronizer. SCK rising edge is detected from the synchronized value and its 1-cycle delayed copy.
- Bit capture happens only on a detected rise while the synchronized `tft_cs` is 0. SDI shifts into an 8-bit register and a 3-bit counter increments.
- On the 8th bit, the byte is complete, tagged with the synchronized `tft_dc` sampled on that same rise.
- Synchronized `tft_cs` = 1 clears the bit counter and discards the partial byte. Decoder state is retained, except a pending high pixel byte is dropped (RAMWR_LO→RAMWR_HI).
- Synchronized `tft_reset` = 0 acts like `rst_in`, applied synchronously.
- A command byte (dc = 0) in any state does three things: pulses `cmd_valid`, loads `cmd_out`, and selects the next state:
  - 0x2A → CASET
  - 0x2B → PASET
  - 0x2C → RAMWR_HI, with the cursor loaded to (col_start, row_start)
  - anything else → IDLE
- CASET/PASET:
  - Data bytes 0..3 form start[15:8], start[7:0], end[15:8], end[7:0] into shadow registers.
  - On byte 3 the shadow commits to the window and the state goes to IDLE.
  - Fewer than 4 bytes followed by a command leaves the window unchanged.
- RAMWR_HI: a data byte stores the pixel high byte → RAMWR_LO.
- RAMWR_LO: a data byte pulses `pixel_valid` with the cursor and {hi, lo} → RAMWR_HI. Cursor advance:
  - if col == col_end: col ← col_start; then row ← (row == row_end) ? row_start : row+1
  - else col+1
  - Comparisons use 16-bit equality. A cursor past end (end < start) is not an equality match, so it increments and wraps modulo 2^16.
- In IDLE, data bytes are ignored.
- States: IDLE, CASET, PASET, RAMWR_HI, RAMWR_LO. Byte index 0..3 is shared by CASET and PASET.

## Timing
- Reset values:
  - all outputs 0
  - state IDLE, cursor (0,0)
  - col window 0..COL_END_RST, row window 0..ROW_END_RST
  - synchronizers 0, except the `tft_cs` and `tft_reset` synchronizers, which reset to 1
- Input requirement: SCK high and low each ≥ 2 `clk_in` periods; `tft_dc` stable across the whole byte.
- Latency: the completed byte is registered the cycle after the edge detect. `cmd_valid`/`pixel_valid` assert the following cycle, 5 cycles after the 8th SCK rise at the pin.
- Pulses are exactly 1 cycle; at most one event per byte. `cmd_out`, `col_out`, `row_out`, `pixel_out` hold until the next event.
- The async `rst_in` assertion mid-byte clears everything immediately. The first sync edge is counted only after deassertion + 2 cycles.

## Structure
- Package `tft_pkg`: opcode constants CMD_CASET = 8'h2A, CMD_PASET = 8'h2B, CMD_RAMWR = 8'h2C; state enum `dec_state_t`.
- Sub-module `spi_byte_rx`: synchronizers, edge detect, shift register and bit counter. Outputs `byte_valid`, `byte_data[7:0]`, `byte_dc`, `cs_high`, `panel_rst`.
- The top level holds the command FSM, window registers and cursor.

## Test plan
- Command bytes 0x2A, then data 00 64 00 96; then 0x2B, then data 00 C8 00 FA → window col 100..150, row 200..250; `cmd_valid` pulsed twice with 0x2A, 0x2B.
- With that window, 0x2C then data F8 00 07 E0 → pixels (100,200)=F800, (101,200)=07E0.
- Window col 10..11, row 5..6, stream 5 pixels → coordinates (10,5),(11,5),(10,6),(11,6),(10,5).
- CS high after 5 bits of a byte, then a full byte 0x2C → only 0x2C decoded, no spurious event.
- CASET with only 2 data bytes, then 0x2C and 1 pixel → pixel at the old window start (0,0).
- `rst_in` low mid-RAMWR → outputs 0 immediately. After release, a pixel stream without RAMWR produces no `pixel_valid`.
